// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_umbral family of buffers.
package fifo_pkg;

    localparam int DW_DEF = 10;
    localparam int AW_DEF = 3;

    function automatic int fifo_depth(input int aw);
        return 32'sd1 << aw;
    endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Producer/consumer bus of fifo_umbral: push/pop requests, thresholds and status.
interface fifo_umbral_if
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
  logic          write_enable;
  logic          read_enable;
  logic [DW-1:0] data_in;
  logic [AW:0]   umbral_alto;
  logic [AW:0]   umbral_bajo;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   fill_level;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  modport master (
    output write_enable, read_enable, data_in, umbral_alto, umbral_bajo,
    input  data_out, valid_out, fill_level, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  write_enable, read_enable, data_in, umbral_alto, umbral_bajo,
    output data_out, valid_out, fill_level, full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage for fifo_umbral; registered read port, or
// combinational read when FIFO_FWFT_EN is defined.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem_r [DEPTH];

  // Write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  logic unused_s;
  assign unused_s = re ^ reset;
  assign rdata    = mem_r[raddr];
`else
  logic [DW-1:0] rdata_r;

  // Read register: loads only on a pop, otherwise holds the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;
`endif
endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, fill level
// and sticky overflow/underflow error. Define FIFO_FWFT_EN for fall-through reads.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int tamano_datos    = DW_DEF,
  parameter int tamano_direcion = AW_DEF
) (
  input logic          clk,
  input logic          reset,
  fifo_umbral_if.slave bus
);
  localparam int DW    = tamano_datos;
  localparam int AW    = tamano_direcion;
  localparam int DEPTH = fifo_depth(AW);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   fill_r;
  logic          error_r;
  logic          rd_acc_s, wr_acc_s;
  logic          full_s, empty_s, almost_full_s, almost_empty_s;
  logic [DW-1:0] rdata_s;

  // Status flags and accept decisions, all combinational from occupancy.
  always_comb begin
    full_s         = (fill_r == DEPTH_L);
    empty_s        = (fill_r == {(AW+1){1'b0}});
    almost_full_s  = (fill_r >= bus.umbral_alto);
    almost_empty_s = (fill_r <= bus.umbral_bajo);
    rd_acc_s       = bus.read_enable & ~empty_s;
    wr_acc_s       = bus.write_enable & (~full_s | rd_acc_s);
  end

  // Pointers, occupancy counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {(AW+1){1'b0}};
      error_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
      error_r <= error_r | (bus.write_enable & ~wr_acc_s) | (bus.read_enable & empty_s);
    end
  end

  fifo_mem_dp #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r),
    .wdata (bus.data_in),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

`ifdef FIFO_FWFT_EN
  assign bus.valid_out = ~empty_s;
`else
  logic valid_r;

  // A popped word is presented one cycle after its read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= rd_acc_s;
    end
  end

  assign bus.valid_out = valid_r;
`endif

  assign bus.data_out     = rdata_s;
  assign bus.fill_level   = fill_r;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = almost_full_s;
  assign bus.almost_empty = almost_empty_s;
  assign bus.error        = error_r;
endmodule

// File: tb/tb_fifo_umbral.sv
// Directed self-checking bench for fifo_umbral (standard read mode, DW=10, AW=3).
module tb_fifo_umbral;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  fifo_umbral_if #(.DW(10), .AW(3)) bus ();

  fifo_umbral #(
    .tamano_datos    (10),
    .tamano_direcion (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic [9:0] din);
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.data_in      = din;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_fill"},  32'(bus.fill_level), 32'd0);
    check_eq({tag, "_empty"}, 32'(bus.empty), 32'd1);
    check_eq({tag, "_full"},  32'(bus.full), 32'd0);
    check_eq({tag, "_ae"},    32'(bus.almost_empty), 32'd1);
    check_eq({tag, "_af"},    32'(bus.almost_full), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
    check_eq({tag, "_dout"},  32'(bus.data_out), 32'd0);
    check_eq({tag, "_err"},   32'(bus.error), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset            = 1'b1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.data_in      = 10'h000;
    bus.umbral_alto  = 4'd6;
    bus.umbral_bajo  = 4'd1;
    #12;
    check_reset_state("rst");
    bus.umbral_alto = 4'd0;
    #1;
    check_eq("rst_af_thr0", 32'(bus.almost_full), 32'd1);
    bus.umbral_alto = 4'd6;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, watching thresholds.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 10'(i));
      check_eq($sformatf("fill_w%0d", i),  32'(bus.fill_level), 32'(i));
      check_eq($sformatf("af_w%0d", i),    32'(bus.almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check_eq($sformatf("ae_w%0d", i),    32'(bus.almost_empty), (i <= 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("full_w%0d", i),  32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
      check_eq($sformatf("err_w%0d", i),   32'(bus.error), 32'd0);
    end
    bus.umbral_alto = 4'd9;
    #1;
    check_eq("af_thr_over_depth", 32'(bus.almost_full), 32'd0);
    bus.umbral_alto = 4'd6;
    #1;

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 10'h000);
      check_eq($sformatf("valid_r%0d", i), 32'(bus.valid_out), 32'd1);
      check_eq($sformatf("dout_r%0d", i),  32'(bus.data_out), 32'(i));
    end
    step(1'b0, 1'b0, 10'h000);
    check_eq("drain_valid", 32'(bus.valid_out), 32'd0);
    check_eq("drain_hold",  32'(bus.data_out), 32'h008);
    check_eq("drain_empty", 32'(bus.empty), 32'd1);
    check_eq("drain_err",   32'(bus.error), 32'd0);

    // Overflow drop, then full simultaneous push/pop.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h011 + 10'(i));
    step(1'b1, 1'b0, 10'h3FF);
    check_eq("ovf_fill", 32'(bus.fill_level), 32'd8);
    check_eq("ovf_err",  32'(bus.error), 32'd1);
    step(1'b0, 1'b0, 10'h000);
    check_eq("ovf_err_sticky", 32'(bus.error), 32'd1);
    step(1'b1, 1'b1, 10'h155);
    check_eq("rw_full_fill",  32'(bus.fill_level), 32'd8);
    check_eq("rw_full_dout",  32'(bus.data_out), 32'h011);
    check_eq("rw_full_valid", 32'(bus.valid_out), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1, 10'h000);
      check_eq($sformatf("after_rw_r%0d", i), 32'(bus.data_out), 32'h011 + 32'(i));
    end
    step(1'b0, 1'b1, 10'h000);
    check_eq("last_is_155", 32'(bus.data_out), 32'h155);
    check_eq("last_empty",  32'(bus.empty), 32'd1);

    // Clean reset, then read-while-empty with a write.
    reset = 1'b1;
    #2;
    check_reset_state("rst2");
    reset = 1'b0;
    step(1'b1, 1'b1, 10'h0AA);
    check_eq("udf_fill",  32'(bus.fill_level), 32'd1);
    check_eq("udf_valid", 32'(bus.valid_out), 32'd0);
    check_eq("udf_err",   32'(bus.error), 32'd1);
    step(1'b0, 1'b1, 10'h000);
    check_eq("udf_dout",  32'(bus.data_out), 32'h0AA);
    check_eq("udf_valid2", 32'(bus.valid_out), 32'd1);

    // Streaming burst across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h100 + 10'(i));
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 10'h200 + 10'(k));
      check_eq($sformatf("burst_dout%0d", k), 32'(bus.data_out),
               (k < 3) ? (32'h100 + 32'(k)) : (32'h200 + 32'(k - 3)));
      check_eq($sformatf("burst_fill%0d", k), 32'(bus.fill_level), 32'd3);
    end

    // Asynchronous reset in the middle of the burst.
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.data_in      = 10'h3C3;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 10'h000);
    check_eq("post_rst_fill",  32'(bus.fill_level), 32'd0);
    check_eq("post_rst_empty", 32'(bus.empty), 32'd1);
    step(1'b1, 1'b0, 10'h077);
    step(1'b0, 1'b1, 10'h000);
    check_eq("post_rst_dout", 32'(bus.data_out), 32'h077);
    check_eq("post_rst_fill0", 32'(bus.fill_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
